tiny_mmio_uart_tx: RTL and testbench
====================================

TINY_MMIO_UART_TX -- requirements
Module: tiny_mmio_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: the reset value of the DIVISOR register, in clocks per serial bit.
REQ-002 Parameter FIFO_DEPTH, default 8: the TX FIFO depth; it SHALL be a power of two, from 2 to 16.
REQ-003 clk  in  1  single clock; all logic SHALL use its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 mem_valid  in  1  request from the initiator, held until mem_ready.
REQ-006 mem_we  in  1  1 = write, 0 = read.
REQ-007 mem_addr  in  32  byte address; only [3:2] SHALL be decoded (external interconnect selects the block).
REQ-008 mem_wdata  in  32  write data.
REQ-009 mem_wstrb  in  4  byte write strobes.
REQ-010 mem_ready  out  1  one-cycle completion pulse.
REQ-011 mem_rdata  out  32  read data, valid only while mem_ready=1.
REQ-012 uart_tx  out  1  serial line, idle high.

Function
REQ-013 Handshake: a request SHALL be accepted in any cycle with mem_valid=1 and mem_ready=0; mem_ready SHALL be 1 in the following cycle only (1-cycle latency, never 2 consecutive cycles).
REQ-014 Register map (offset): 0x0 TXDATA (W), 0x4 STATUS (R/W1C), 0x8 DIVISOR (R/W, [15:0]), 0xC reserved (reads 0, writes ignored).
REQ-015 TXDATA write with wstrb[0]=1 SHALL push wdata[7:0]; if the FIFO is full and no pop occurs that cycle, the byte SHALL be dropped and OVF set; reads of TXDATA SHALL return 0.
REQ-016 STATUS read = {24'b0, count[3:0], OVF, empty, full, busy} in bits [7:0]; the write of a 1 to bit3 with wstrb[0]=1 SHALL clear OVF; other bits read-only.
REQ-017 DIVISOR write SHALL update the bytes selected by wstrb[1:0]; value 0 SHALL be treated as 1.
REQ-018 mem_rdata SHALL be 0 except during the mem_ready cycle of a read; reads SHALL have no side effects.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged, including when the FIFO is full or empty.
REQ-020 Serializer states IDLE, START, DATA, PARITY (see REQ-029), STOP.
- IDLE: uart_tx=1; when the FIFO is non-empty, pop the byte, latch DIVISOR, and enter START next cycle.
REQ-021 Each state other than IDLE SHALL hold uart_tx for exactly the latched divisor clocks.
- START drives 0.
- DATA drives 8 bits, LSB first.
- STOP drives 1.
- STOP then returns to IDLE; back-to-back bytes SHALL incur exactly 1 idle clock between the stop and the next start.
REQ-022 A DIVISOR write mid-frame SHALL take effect only at the next frame start.
REQ-023 busy = (state != IDLE); full = (count == FIFO_DEPTH); empty = (count == 0).

Reset
REQ-024 While rst_n=0 at a clock edge, the block SHALL apply all of the following:
- mem_ready=0 and mem_rdata=0.
- uart_tx=1 and state=IDLE.
- count=0 and FIFO pointers=0.
- OVF=0.
- DIVISOR=CLKS_PER_BIT.
REQ-025 Reset mid-frame SHALL abort the frame, with uart_tx high from the first reset edge.
REQ-026 Reset with a request pending SHALL drop that request, with no mem_ready.
REQ-027 The first request SHALL be accepted in the first cycle with rst_n=1.

Configuration
REQ-028 Macro TINY_UART_TX_PARITY_EN SHALL compile the parity feature in or out.
REQ-029 With TINY_UART_TX_PARITY_EN defined, PARITY SHALL sit between DATA and STOP and drive the even-parity bit (XOR of the 8 data bits) for divisor clocks; frame = 11 bits.
REQ-030 With TINY_UART_TX_PARITY_EN undefined, no PARITY state SHALL exist and frame = 10 bits; the register map SHALL be identical in both builds.

Verification
REQ-031 Reset, then read 0x4 and 0x8 -> STATUS=0x00000004, DIVISOR=0x00000010; each mem_ready 1 cycle after acceptance.
REQ-032 DIVISOR=4, write 0x55 to 0x0 -> uart_tx: 0 for 4 clk, then 1,0,1,0,1,0,1,0 at 4 clk each, then stop 1; 40 clk total without parity, 44 with parity bit=0.
REQ-033 DIVISOR=4, write 9 bytes back-to-back while the first frame is active -> 9th push is dropped only if the FIFO is full; STATUS.OVF=1 and count=8; writing 0x8 to 0x4 clears OVF.
REQ-034 Write 0x01 then 0x02 -> exactly 1 idle-high clock between frames; STATUS busy=1 until the second stop ends, then 0x00000004.
REQ-035 Assert rst_n=0 for 1 cycle mid-DATA -> uart_tx=1 the next cycle, STATUS=0x00000004, DIVISOR=0x10.
REQ-036 Write DIVISOR=8 mid-frame at divisor 4 -> current frame bits stay 4 clk, next frame bits 8 clk; DIVISOR=0 gives 1 clk/bit.

Source files
------------

// File: rtl/tiny_mmio_uart_tx_if.sv
// Memory-mapped request/response bundle between an initiator and the tiny UART transmitter.
interface tiny_mmio_uart_tx_if;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/tiny_mmio_uart_tx.sv
// MMIO-programmed UART transmitter with a byte FIFO and runtime divisor.
// Define TINY_UART_TX_PARITY_EN to add an even-parity bit to every frame.
module tiny_mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  tiny_mmio_uart_tx_if.slave  bus,
  output logic                uart_tx
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned DIV_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef TINY_UART_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic [DIV_W-1:0] divisor;

  state_t           state;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par;

  logic             accept_c;
  logic             wr_c;
  logic [1:0]       sel_c;
  logic             push_req_c;
  logic             push_c;
  logic             pop_c;
  logic             ovf_set_c;
  logic             ovf_clr_c;
  logic             div_wr_c;
  logic             full_c;
  logic             empty_c;
  logic             busy_c;
  logic             bit_end_c;
  logic [7:0]       status_c;
  logic [31:0]      rdata_c;
  logic             unused_bits;

  assign accept_c   = bus.mem_valid && !bus.mem_ready;
  assign wr_c       = accept_c && bus.mem_we;
  assign sel_c      = bus.mem_addr[3:2];
  assign full_c     = (count == CNT_W'(FIFO_DEPTH));
  assign empty_c    = (count == '0);
  assign busy_c     = (state != ST_IDLE);
  assign pop_c      = (state == ST_IDLE) && !empty_c;
  assign push_req_c = wr_c && (sel_c == 2'd0) && bus.mem_wstrb[0];
  // A full FIFO still takes a byte when the serializer pops in the same cycle.
  assign push_c     = push_req_c && (!full_c || pop_c);
  assign ovf_set_c  = push_req_c && full_c && !pop_c;
  assign ovf_clr_c  = wr_c && (sel_c == 2'd1) && bus.mem_wstrb[0] && bus.mem_wdata[3];
  assign div_wr_c   = wr_c && (sel_c == 2'd2);
  assign status_c   = {4'(count), ovf, empty_c, full_c, busy_c};
  assign bit_end_c  = (bit_cnt == div_lat - DIV_W'(1));

  assign unused_bits = ^{bus.mem_addr[31:4], bus.mem_addr[1:0],
                         bus.mem_wdata[31:16], bus.mem_wstrb[3:2]};

  // Register read mux; TXDATA and the reserved slot read as zero.
  always_comb begin
    rdata_c = '0;
    case (sel_c)
      2'd1:    rdata_c = {24'b0, status_c};
      2'd2:    rdata_c = {16'b0, divisor};
      default: rdata_c = '0;
    endcase
  end

  // Bus response, FIFO bookkeeping and control registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      ovf           <= 1'b0;
      divisor       <= DIV_W'(CLKS_PER_BIT);
    end else begin
      bus.mem_ready <= accept_c;
      bus.mem_rdata <= (accept_c && !bus.mem_we) ? rdata_c : '0;
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_c && !pop_c)      count <= count + CNT_W'(1);
      else if (!push_c && pop_c) count <= count - CNT_W'(1);
      if (ovf_set_c)      ovf <= 1'b1;
      else if (ovf_clr_c) ovf <= 1'b0;
      if (div_wr_c && bus.mem_wstrb[0]) divisor[7:0]  <= bus.mem_wdata[7:0];
      if (div_wr_c && bus.mem_wstrb[1]) divisor[15:8] <= bus.mem_wdata[15:8];
    end
  end

  // FIFO storage carries no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
  end

  // Serializer: uart_tx is loaded together with the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      uart_tx <= 1'b1;
      div_lat <= DIV_W'(1);
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          uart_tx <= 1'b1;
          bit_cnt <= '0;
          if (pop_c) begin
            shreg   <= fifo_mem[rd_ptr];
            par     <= ^fifo_mem[rd_ptr];
            div_lat <= (divisor == '0) ? DIV_W'(1) : divisor;
            state   <= ST_START;
            uart_tx <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end_c) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= ST_DATA;
            uart_tx <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + DIV_W'(1);
          end
        end
        ST_DATA: begin
          if (bit_end_c) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef TINY_UART_TX_PARITY_EN
              state   <= ST_PARITY;
              uart_tx <= par;
`else
              state   <= ST_STOP;
              uart_tx <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'(1);
              shreg   <= {1'b0, shreg[7:1]};
              uart_tx <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + DIV_W'(1);
          end
        end
`ifdef TINY_UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end_c) begin
            bit_cnt <= '0;
            state   <= ST_STOP;
            uart_tx <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + DIV_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (bit_end_c) begin
            bit_cnt <= '0;
            state   <= ST_IDLE;
            uart_tx <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + DIV_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tiny_mmio_uart_tx.sv
// Directed self-checking bench for tiny_mmio_uart_tx: register map, framing, FIFO overflow, reset.
module tb_tiny_mmio_uart_tx;
`ifdef TINY_UART_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic uart_tx;
  int   n_checks = 0;
  int   n_errors = 0;

  tiny_mmio_uart_tx_if bus();

  tiny_mmio_uart_tx #(.CLKS_PER_BIT(16), .FIFO_DEPTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata, output int lat);
    bus.mem_valid = 1'b1;
    bus.mem_we    = we;
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = strb;
    lat = 0;
    do begin
      step();
      lat++;
    end while (bus.mem_ready !== 1'b1 && lat < 20);
    if (bus.mem_ready !== 1'b1) check_eq("bus_timeout", 32'(bus.mem_ready), 32'd1);
    rdata = bus.mem_rdata;
    bus.mem_valid = 1'b0;
  endtask

  task automatic reg_wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] d;
    int l;
    bus_xfer(1'b1, addr, wdata, strb, d, l);
  endtask

  task automatic reg_rd(input logic [31:0] addr, output logic [31:0] d, output int lat);
    bus_xfer(1'b0, addr, 32'h0, 4'h0, d, lat);
  endtask

  // Wait for the start bit, then compare every clock of the frame to the expected line level.
  task automatic capture_frame(input string tag, input logic [7:0] b, input int div, output int waited);
    logic exp_bits [11];
    int   nb;
    int   err;
    nb = 10 + PAR_BITS;
    exp_bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
    if (PAR_BITS == 1) exp_bits[9] = ^b;
    exp_bits[nb-1] = 1'b1;
    waited = 0;
    while (uart_tx !== 1'b0 && waited < 400) begin
      step();
      waited++;
    end
    check_eq({tag, "_start"}, 32'(uart_tx), 32'd0);
    err = 0;
    for (int k = 0; k < nb; k++) begin
      for (int c = 0; c < div; c++) begin
        if (!(k == 0 && c == 0)) step();
        if (uart_tx !== exp_bits[k]) err++;
      end
    end
    check_eq({tag, "_wave"}, 32'(err), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] d2;
    int lat;
    int lat2;
    int w1;
    int w2;
    int wf;
    logic prev;

    bus.mem_valid = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    rst_n = 1'b0;
    repeat (3) step();
    check_eq("rst_ready", 32'(bus.mem_ready), 32'd0);
    check_eq("rst_rdata", bus.mem_rdata, 32'd0);
    check_eq("rst_uart_tx", 32'(uart_tx), 32'd1);

    // First request issued in the very first cycle out of reset.
    rst_n = 1'b1;
    reg_rd(32'h4, d, lat);
    check_eq("status_rst", d, 32'h0000_0004);
    check_eq("status_lat", 32'(lat), 32'd1);
    step();
    check_eq("rdata_idle_zero", bus.mem_rdata, 32'd0);
    reg_rd(32'h8, d, lat);
    check_eq("divisor_rst", d, 32'h0000_0010);
    check_eq("divisor_lat", 32'(lat), 32'd1);
    step();
    reg_rd(32'h0, d, lat);
    check_eq("txdata_reads_zero", d, 32'd0);
    reg_wr(32'hC, 32'hFFFF_FFFF, 4'hF);
    reg_rd(32'hC, d, lat);
    check_eq("reserved_zero", d, 32'd0);

    // Byte-strobed divisor writes.
    bus_xfer(1'b1, 32'h8, 32'h0000_ABCD, 4'b0001, d, lat);
    check_eq("wr_rdata_zero", d, 32'd0);
    reg_rd(32'h8, d, lat);
    check_eq("divisor_lo_byte", d, 32'h0000_00CD);
    reg_wr(32'h8, 32'h0000_1200, 4'b0010);
    reg_rd(32'h8, d, lat);
    check_eq("divisor_hi_byte", d, 32'h0000_12CD);

    reg_wr(32'h8, 32'h4, 4'b0011);
    reg_wr(32'h0, 32'h55, 4'b0001);
    capture_frame("f55", 8'h55, 4, wf);
    step();
    check_eq("f55_idle_after", 32'(uart_tx), 32'd1);
    reg_rd(32'h4, d, lat);
    check_eq("f55_status_done", d, 32'h0000_0004);

    // Back-to-back bytes: one idle clock between stop and next start.
    fork
      begin
        capture_frame("b2b_1", 8'h01, 4, w1);
        capture_frame("b2b_2", 8'h02, 4, w2);
        check_eq("b2b_gap", 32'(w2), 32'd2);
      end
      begin
        reg_wr(32'h0, 32'h01, 4'b0001);
        reg_wr(32'h0, 32'h02, 4'b0001);
        repeat (50) step();
        reg_rd(32'h4, d2, lat2);
        check_eq("b2b_busy", d2, 32'h0000_0005);
      end
    join
    step();
    reg_rd(32'h4, d, lat);
    check_eq("b2b_status_done", d, 32'h0000_0004);

    // Overflow: fill the FIFO while a frame is on the wire.
    reg_wr(32'h0, 32'hFE, 4'b0001);
    repeat (3) step();
    for (int i = 0; i < 9; i++) reg_wr(32'h0, 32'hFE, 4'b0001);
    reg_rd(32'h4, d, lat);
    check_eq("ovf_status", d, 32'h0000_008B);
    reg_wr(32'h4, 32'h0, 4'b0001);
    reg_rd(32'h4, d, lat);
    check_eq("ovf_hold", d, 32'h0000_008B);
    reg_wr(32'h4, 32'h8, 4'b0001);
    reg_rd(32'h4, d, lat);
    check_eq("ovf_cleared", d, 32'h0000_0083);

    // Reset mid-DATA with a read pending.
    prev = uart_tx;
    wf = 0;
    step();
    while (!(prev === 1'b1 && uart_tx === 1'b0) && wf < 200) begin
      prev = uart_tx;
      step();
      wf++;
    end
    repeat (5) step();
    check_eq("mid_data_low", 32'(uart_tx), 32'd0);
    rst_n = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h4;
    step();
    check_eq("rst_abort_tx", 32'(uart_tx), 32'd1);
    check_eq("rst_drop_ready", 32'(bus.mem_ready), 32'd0);
    check_eq("rst_drop_rdata", bus.mem_rdata, 32'd0);
    bus.mem_valid = 1'b0;
    rst_n = 1'b1;
    reg_rd(32'h4, d, lat);
    check_eq("post_rst_status", d, 32'h0000_0004);
    check_eq("post_rst_lat", 32'(lat), 32'd1);
    reg_rd(32'h8, d, lat);
    check_eq("post_rst_divisor", d, 32'h0000_0010);
    repeat (10) step();
    check_eq("post_rst_idle", 32'(uart_tx), 32'd1);

    // Divisor change mid-frame applies from the next frame; 0 behaves as 1.
    reg_wr(32'h8, 32'h4, 4'b0011);
    reg_wr(32'h0, 32'h0F, 4'b0001);
    fork
      capture_frame("div_cur", 8'h0F, 4, wf);
      begin
        repeat (8) step();
        reg_wr(32'h8, 32'h8, 4'b0011);
      end
    join
    reg_wr(32'h0, 32'hA7, 4'b0001);
    capture_frame("div_next", 8'hA7, 8, wf);
    reg_wr(32'h8, 32'h0, 4'b0011);
    reg_wr(32'h0, 32'h3C, 4'b0001);
    capture_frame("div_zero", 8'h3C, 1, wf);
    step();
    check_eq("div_zero_idle", 32'(uart_tx), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
